lfsr_arbiter: RTL and testbench
===============================

# lfsr_arbiter

Shares the single 16-bit LFSR random source (LFSR_16) among up to N_REQ game-logic clients (enemy movement, power-up drops, bomb timers) with fair round-robin arbitration. Owns the LFSR seed-load port: it seeds the LFSR after reset and on reseed requests. Every grant returns a distinct, freshly sampled LFSR value. Sits between LFSR_16 and the gameplay FSMs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DEFAULT_SEED, 16'h684C, seed loaded after reset and substituted for any zero seed
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  N_REQ  per-client request, level; held until that client's ack
- ack  out  N_REQ  one-hot, one-cycle pulse; rnd_data valid for that client
- rnd_data  out  16  sampled random value, valid when ack != 0
- grant_id  out  3  index of client acked this cycle (0 when ack == 0)
- seed_req  in  1  one-cycle pulse: reseed the LFSR with seed_val
- seed_val  in  16  reseed value, sampled with seed_req
- busy  out  1  high while seeding; requests are ignored, not dropped
- lfsr_w_en  out  1  to LFSR_16 w_en
- lfsr_w_in  out  16  to LFSR_16 w_in
- lfsr_data  in  16  from LFSR_16 LFSR_out (advances every clk)

## Operation
- FSM states: SEED, SETTLE, RUN.
  - SEED: lfsr_w_en=1, lfsr_w_in=seed register; next SETTLE.
  - SETTLE: lfsr_w_en=0, one wait cycle while the LFSR loads; next RUN.
  - RUN: arbitrate; on seed_req go to SEED.
- busy = (state != RUN).
- Seed register: reset to DEFAULT_SEED. On seed_req in RUN it captures seed_val, or DEFAULT_SEED if seed_val == 0, which prevents LFSR lockup. seed_req outside RUN is ignored.
- Arbitration in RUN (no seed_req):
  - Search req starting at pointer ptr, wrapping modulo N_REQ; the first set bit i wins.
  - Register ack = 1<<i, grant_id = i, rnd_data = lfsr_data.
  - ptr <= (i+1) mod N_REQ.
  - No set bit: ack = 0, ptr unchanged.
- At most one grant per cycle. Because the LFSR advances every clk, consecutive grants carry distinct samples.
- A client holding req after its ack re-enters rotation and is not favoured.
- Simultaneous seed_req and pending req in RUN: seed wins, no grant that cycle, requests wait.
- Outputs rnd_data and grant_id hold their last values when ack == 0, except that grant_id is 0 whenever ack == 0.

## Timing
- Reset values (while rst=0): state=SEED, ptr=0, ack=0, grant_id=0, rnd_data=0, busy=1, lfsr_w_en=1, lfsr_w_in=DEFAULT_SEED.
- After rst release: cycle 0 SEED, cycle 1 SETTLE, cycle 2 RUN (busy=0). The earliest ack appears at cycle 3.
- Latency: req sampled high at edge t in RUN gives ack at t+1. A request waits at most N_REQ cycles under full load.
- Requester rule: sample rnd_data on the cycle ack[i]=1. Deassert req in that same cycle to avoid a second grant; otherwise another grant follows in rotation.
- Reseed: seed_req at edge t gives busy=1 and lfsr_w_en=1 in cycle t+1, SETTLE at t+2, RUN at t+3.
- Reset asserted mid-operation: every output returns to its reset value at the next edge. An in-flight ack is cancelled and must not be presented.

## Test plan
- Reset then idle: release rst -> lfsr_w_en=1 with lfsr_w_in=16'h684C for one cycle, busy falls at cycle 2, ack stays 0.
- Single client: req=4'b0010 held -> ack=4'b0010 every cycle from cycle 3, grant_id=1, rnd_data equals lfsr_data from the prior cycle and is never equal on consecutive acks.
- Full load: req=4'b1111 held -> ack sequence 0001, 0010, 0100, 1000, 0001…, with each client acked exactly once per 4 cycles.
- Fairness with gaps: req=4'b1001 after a grant to client 0 -> next ack goes to client 3, then back to client 0.
- Reseed collision: seed_req with seed_val=16'h0000 while req=4'b0001 -> no ack that cycle, lfsr_w_in=16'h684C, busy high for 2 cycles, ack resumes once back in RUN.
- Mid-grant reset: rst low in the cycle after a grant decision -> ack=0, rnd_data=0, ptr=0 at the next edge, and the seed sequence restarts.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that hands out samples of a shared 16-bit LFSR to N_REQ clients.
// It also owns the LFSR seed port: it seeds after reset and on reseed requests.
module lfsr_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter logic [15:0] DEFAULT_SEED = 16'h684C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [15:0]      rnd_data,
    output logic [2:0]       grant_id,
    input  logic             seed_req,
    input  logic [15:0]      seed_val,
    output logic             busy,
    output logic             lfsr_w_en,
    output logic [15:0]      lfsr_w_in,
    input  logic [15:0]      lfsr_data
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [2:0]       ptr_r;
    logic [2:0]       ptr_nxt_s;
    logic [15:0]      seed_r;
    logic [N_REQ-1:0] ack_r;
    logic [N_REQ-1:0] ack_nxt_s;
    logic [2:0]       grant_id_r;
    logic [15:0]      rnd_data_r;
    logic             win_found_s;
    logic [2:0]       win_idx_s;
    logic             hit_s;
    logic             grant_s;

    // Round-robin search: first pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        hit_s       = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            hit_s       = req[i] && (3'(i) >= ptr_r) && !win_found_s;
            win_idx_s   = hit_s ? 3'(i) : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            hit_s       = req[i] && (3'(i) < ptr_r) && !win_found_s;
            win_idx_s   = hit_s ? 3'(i) : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    // Grant qualification, one-hot ack vector and rotated pointer for the winner.
    always_comb begin
        grant_s   = (state_r == ST_RUN) && !seed_req && win_found_s;
        ptr_nxt_s = (win_idx_s == 3'(N_REQ - 1)) ? 3'd0 : (win_idx_s + 3'd1);
        ack_nxt_s = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            ack_nxt_s[i] = grant_s && (win_idx_s == 3'(i));
        end
    end

    // Next-state logic; a reseed request only counts while running.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SEED:   state_s = ST_SETTLE;
            ST_SETTLE: state_s = ST_RUN;
            ST_RUN: begin
                if (seed_req) begin
                    state_s = ST_SEED;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default:   state_s = ST_SEED;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_SEED;
        end else begin
            state_r <= state_s;
        end
    end

    // Seed register; a zero seed would lock the LFSR up, so it is replaced by the default.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seed_r <= DEFAULT_SEED;
        end else if ((state_r == ST_RUN) && seed_req) begin
            seed_r <= (seed_val == 16'h0000) ? DEFAULT_SEED : seed_val;
        end else begin
            seed_r <= seed_r;
        end
    end

    // Grant registers; rnd_data holds between grants while grant_id returns to 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r      <= 3'd0;
            ack_r      <= '0;
            grant_id_r <= 3'd0;
            rnd_data_r <= 16'h0000;
        end else if (grant_s) begin
            ptr_r      <= ptr_nxt_s;
            ack_r      <= ack_nxt_s;
            grant_id_r <= win_idx_s;
            rnd_data_r <= lfsr_data;
        end else begin
            ptr_r      <= ptr_r;
            ack_r      <= '0;
            grant_id_r <= 3'd0;
            rnd_data_r <= rnd_data_r;
        end
    end

    assign ack       = ack_r;
    assign grant_id  = grant_id_r;
    assign rnd_data  = rnd_data_r;
    assign busy      = (state_r != ST_RUN);
    assign lfsr_w_en = (state_r == ST_SEED);
    assign lfsr_w_in = seed_r;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Scoreboard bench for lfsr_arbiter with a behavioural LFSR_16 source.
// Stimulus pushes hand-computed grants; a negedge monitor pops and compares them.
module tb_lfsr_arbiter;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  ack;
        logic [2:0]  id;
        logic [15:0] rnd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [15:0] rnd_data;
    logic [2:0]  grant_id;
    logic        seed_req;
    logic [15:0] seed_val;
    logic        busy;
    logic        lfsr_w_en;
    logic [15:0] lfsr_w_in;
    logic [15:0] lfsr_q = 16'h0001;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = 32'd0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] last_rnd = 16'h0000;
    logic [31:0] last_cyc = 32'd0;

    always #5 clk = ~clk;

    lfsr_arbiter #(.N_REQ(4), .DEFAULT_SEED(16'h684C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .rnd_data  (rnd_data),
        .grant_id  (grant_id),
        .seed_req  (seed_req),
        .seed_val  (seed_val),
        .busy      (busy),
        .lfsr_w_en (lfsr_w_en),
        .lfsr_w_in (lfsr_w_in),
        .lfsr_data (lfsr_q)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // LFSR_16 stand-in: loads when w_en is high, otherwise steps every clock.
    always @(posedge clk) begin
        cyc    <= cyc + 32'd1;
        lfsr_q <= lfsr_w_en ? lfsr_w_in : lfsr_next(lfsr_q);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs; a nonzero ea is the ack expected after the coming edge.
    task automatic step(input logic [3:0] r, input logic sr, input logic [15:0] sv,
                        input logic [3:0] ea, input logic [2:0] eid);
        req      = r;
        seed_req = sr;
        seed_val = sv;
        if (ea != 4'b0000) begin
            sb.push_back('{cyc: cyc + 32'd1, ack: ea, id: eid, rnd: lfsr_q});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(4'b0000, 1'b0, 16'h0000, 4'b0000, 3'd0);
        end
    endtask

    // Monitor: every presented ack must match the oldest expected grant.
    always @(negedge clk) begin
        if (ack != 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=%b required=none (cycle %0d)", ack, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ack", 32'(ack), 32'(mon_e.ack));
                chk("grant_id", 32'(grant_id), 32'(mon_e.id));
                chk("rnd_data", 32'(rnd_data), 32'(mon_e.rnd));
                chk("ack_cycle", cyc, mon_e.cyc);
            end
            if ((last_cyc != 32'd0) && (last_cyc + 32'd1 == cyc)) begin
                chk("rnd_distinct", 32'(rnd_data != last_rnd), 32'd1);
            end
            last_rnd = rnd_data;
            last_cyc = cyc;
        end else begin
            chk("grant_id_idle", 32'(grant_id), 32'd0);
        end
    end

    initial begin
        rst      = 1'b0;
        req      = 4'b0000;
        seed_req = 1'b0;
        seed_val = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rnd", 32'(rnd_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_wen", 32'(lfsr_w_en), 32'd1);
        chk("rst_win", 32'(lfsr_w_in), 32'h684C);

        // Reset release with no requests: SEED, SETTLE, then RUN.
        rst = 1'b1;
        chk("c0_wen", 32'(lfsr_w_en), 32'd1);
        chk("c0_win", 32'(lfsr_w_in), 32'h684C);
        idle(1);
        chk("c1_wen", 32'(lfsr_w_en), 32'd0);
        chk("c1_busy", 32'(busy), 32'd1);
        idle(1);
        chk("c2_busy", 32'(busy), 32'd0);
        idle(2);

        // Single client held: granted every cycle, ptr ends at 2.
        for (int k = 0; k < 4; k++) step(4'b0010, 1'b0, 16'h0000, 4'b0010, 3'd1);
        idle(1);

        // Full load starting from ptr=2.
        for (int k = 0; k < 2; k++) begin
            step(4'b1111, 1'b0, 16'h0000, 4'b0100, 3'd2);
            step(4'b1111, 1'b0, 16'h0000, 4'b1000, 3'd3);
            step(4'b1111, 1'b0, 16'h0000, 4'b0001, 3'd0);
            step(4'b1111, 1'b0, 16'h0000, 4'b0010, 3'd1);
        end
        idle(1);

        // Fairness with gaps: client 0 granted, then 3 and 0 alternate.
        step(4'b0001, 1'b0, 16'h0000, 4'b0001, 3'd0);
        step(4'b1001, 1'b0, 16'h0000, 4'b1000, 3'd3);
        step(4'b1001, 1'b0, 16'h0000, 4'b0001, 3'd0);
        step(4'b1001, 1'b0, 16'h0000, 4'b1000, 3'd3);
        idle(1);

        // Reseed with zero collides with a pending request: seed wins.
        step(4'b0001, 1'b1, 16'h0000, 4'b0000, 3'd0);
        chk("rs_busy0", 32'(busy), 32'd1);
        chk("rs_wen", 32'(lfsr_w_en), 32'd1);
        chk("rs_win", 32'(lfsr_w_in), 32'h684C);
        step(4'b0001, 1'b0, 16'h0000, 4'b0000, 3'd0);
        chk("rs_busy1", 32'(busy), 32'd1);
        chk("rs_wen1", 32'(lfsr_w_en), 32'd0);
        step(4'b0001, 1'b0, 16'h0000, 4'b0000, 3'd0);
        chk("rs_run", 32'(busy), 32'd0);
        step(4'b0001, 1'b0, 16'h0000, 4'b0001, 3'd0);
        chk("rs_rnd", 32'(rnd_data), 32'h3426);
        idle(1);

        // Nonzero reseed: first sample after seeding is one step past ACE1.
        step(4'b0000, 1'b1, 16'hACE1, 4'b0000, 3'd0);
        chk("rs2_win", 32'(lfsr_w_in), 32'hACE1);
        idle(2);
        step(4'b0100, 1'b0, 16'h0000, 4'b0100, 3'd2);
        chk("rs2_rnd", 32'(rnd_data), 32'hE270);

        // Mid-grant reset: grant to client 1 moves ptr to 2, then reset clears everything.
        step(4'b0010, 1'b0, 16'h0000, 4'b0010, 3'd1);
        rst = 1'b0;
        step(4'b0010, 1'b0, 16'h0000, 4'b0000, 3'd0);
        chk("mr_ack", 32'(ack), 32'd0);
        chk("mr_rnd", 32'(rnd_data), 32'd0);
        chk("mr_busy", 32'(busy), 32'd1);
        chk("mr_wen", 32'(lfsr_w_en), 32'd1);
        chk("mr_win", 32'(lfsr_w_in), 32'h684C);
        rst = 1'b1;
        step(4'b1111, 1'b0, 16'h0000, 4'b0000, 3'd0);
        step(4'b1111, 1'b0, 16'h0000, 4'b0000, 3'd0);
        step(4'b1111, 1'b0, 16'h0000, 4'b0001, 3'd0);
        chk("mr_first_rnd", 32'(rnd_data), 32'h3426);
        step(4'b1111, 1'b0, 16'h0000, 4'b0010, 3'd1);
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
